epp_host_bridge: RTL
====================

# epp_host_bridge

Parametrised successor to the team's EPP slave: a synchronous EPP host port that drives a bank of NREG 8-bit operand registers and a command FIFO feeding the graphics core. Adds strobe synchronisation, address auto-increment, a status register and FIFO back-pressure on EppWait. It sits between the board EPP pins and GraphicsCard in the top level.

## Interface
- NREG, 8: number of 8-bit R/W operand registers (addresses 0..NREG-1); NREG+2 <= 128.
- CMD_DEPTH, 4: command FIFO depth, power of two, >= 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- EppAstb  in  1  address strobe, active low, asynchronous to clk.
- EppDstb  in  1  data strobe, active low, asynchronous to clk.
- EppWR  in  1  1 = host read, 0 = host write; sampled with the strobe.
- EppWait  out  1  handshake to host.
- EppDB  inout  8  EPP data bus; driven only during a data or address read.
- regs  out  8*NREG  operand registers, reg i at bits [8i+7:8i].
- cmd_valid  out  1  FIFO head valid.
- cmd_code  out  8  FIFO head byte.
- cmd_ready  in  1  core accepts the head (pop when cmd_valid & cmd_ready).
- busy  in  1  core busy flag, reported in status.

## Operation
- Address map: 0..NREG-1 operand regs (R/W); CMD = NREG: write pushes into FIFO, read returns head (0x00 if empty, no pop); STAT = NREG+1: read-only {busy, full, empty, 2'b0, count[2:0]}; count saturates at 7. Writes to STAT or out-of-range addresses are acknowledged and ignored; such reads return 0x00.
- Address register: 7-bit addr plus auto-increment bit ainc (EppDB[7] on address write). Address read returns {ainc, addr}.
- ainc=1: after each data access to an operand reg, addr increments; at NREG-1 it wraps to 0. No increment at CMD/STAT.
- Strobes pass through 2-flop synchronisers; FSM acts on synchronised levels only.
- FSM states: IDLE, AWR, ARD, DWR, DRD, STALL, RELEASE.
  - IDLE: sync Astb low -> AWR/ARD by EppWR; sync Dstb low -> DWR/DRD. Both low -> address strobe wins.
  - AWR/DWR: latch EppDB, perform the write, go to RELEASE.
  - DWR at CMD with FIFO full and no same-cycle pop -> STALL; STALL performs the push once space exists, then RELEASE.
  - ARD/DRD: drive EppDB with the read value (held until RELEASE exits), then RELEASE.
  - RELEASE: EppWait=1; when both sync strobes are high -> IDLE, EppWait=0, bus released.
- FIFO: push and pop in the same cycle when full is legal, count unchanged. Pop on empty is impossible (cmd_valid=0).
- Reset mid-transfer: FSM to IDLE, EppWait=0, bus Z, FIFO emptied, regs zeroed. A host strobe still low after reset is served as a new access.

## Timing
- Reset values: EppWait 0, EppDB Z, regs 0, cmd_valid 0, cmd_code 0, addr 0, ainc 0.
- Strobe fall to EppWait rise: 3 clk cycles (2 sync + 1 FSM), plus any STALL cycles.
- Strobe rise to EppWait fall: 3 clk cycles.
- Register write is visible on regs at the same edge EppWait rises.
- Push to cmd_valid: 1 cycle (registered FIFO output flags).
- Read data is stable on EppDB at least 1 cycle before EppWait rises.

## Structure
- Package epp_bridge_pkg holds:
  - the FSM state enum;
  - address-offset functions CMD_ADDR(NREG) and STAT_ADDR(NREG);
  - the status bit positions.
- Sub-module cmd_fifo (sync FIFO with width 8, depth CMD_DEPTH, count, full, empty), instantiated once.

## Test plan
- Reset, then write address 0x02 and data 0x5A -> regs[23:16]=0x5A; EppWait rises 3 cycles after Dstb falls and falls 3 cycles after Dstb rises.
- Address write 0x80 (ainc, addr 0), then NREG data writes 0x10..0x17 with NREG=8 -> regs = 0x17..0x10 (high to low); address read returns 0x80 (wrapped).
- With cmd_ready=0, push 5 bytes at CMD with CMD_DEPTH=4 -> 5th access stalls with EppWait low; one-cycle cmd_ready pulse -> stall ends, STAT read = 0x44 (full, count 4).
- Read STAT with FIFO empty and busy=1 -> EppDB=0xA0.
- Push 0x33 with cmd_ready=1 held -> cmd_valid high for exactly 1 cycle with cmd_code=0x33; FIFO ends empty.
- Assert reset while in STALL -> EppWait=0, cmd_valid=0, regs=0 immediately; a later write to reg 1 succeeds normally.

Source files
------------

// File: rtl/epp_host_bridge_pkg.sv
// -----------------------------------------------------------------------------
// epp_bridge_pkg
// Shared definitions for the EPP host bridge:
//   - epp_state_t : host-port FSM states
//   - CMD_ADDR()  : address of the command FIFO port (just above the operand regs)
//   - STAT_ADDR() : address of the read-only status register
//   - STAT_*_BIT  : bit positions inside the status byte
//   - stat_byte() : packs the status byte {busy, full, empty, 2'b0, count[2:0]}
// -----------------------------------------------------------------------------
package epp_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AWR,
        ARD,
        DWR,
        DRD,
        STALL,
        RELEASE
    } epp_state_t;

    localparam int STAT_BUSY_BIT  = 7;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_COUNT_MAX = 7;

    function automatic logic [6:0] CMD_ADDR(input int nreg);
        return 7'(nreg);
    endfunction

    function automatic logic [6:0] STAT_ADDR(input int nreg);
        return 7'(nreg + 1);
    endfunction

    // The count field is only three bits wide, so deeper FIFOs report 7.
    function automatic logic [7:0] stat_byte(input logic busy, input logic full,
                                             input logic empty, input int count);
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_BUSY_BIT]  = busy;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        s[2:0]            = (count > STAT_COUNT_MAX) ? 3'd7 : 3'(count);
        return s;
    endfunction

endpackage

// File: rtl/epp_host_bridge_if.sv
// -----------------------------------------------------------------------------
// epp_host_bridge_if
// Groups the EPP handshake pins and the command port towards the graphics core.
//   EppAstb/EppDstb : active-low strobes from the host (asynchronous to clk)
//   EppWR           : 1 = host read, 0 = host write
//   EppWait         : handshake back to the host
//   cmd_valid/code  : head of the command FIFO
//   cmd_ready       : core accepts the head
//   busy            : core busy flag, reported in the status register
// The bidirectional data bus EppDB stays a plain inout port on the bridge.
// modport master : host / core side      modport slave : bridge side
// -----------------------------------------------------------------------------
interface epp_host_bridge_if;
    logic       EppAstb;
    logic       EppDstb;
    logic       EppWR;
    logic       EppWait;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       cmd_ready;
    logic       busy;

    modport master (
        output EppAstb, EppDstb, EppWR, cmd_ready, busy,
        input  EppWait, cmd_valid, cmd_code
    );

    modport slave (
        input  EppAstb, EppDstb, EppWR, cmd_ready, busy,
        output EppWait, cmd_valid, cmd_code
    );
endinterface

// File: rtl/epp_host_bridge_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous 8-bit FIFO, DEPTH entries (power of two, >= 2).
//   clk, reset  : clock, asynchronous active-high reset (empties the FIFO)
//   push/data   : write request; accepted when not full, or when full with a
//                 simultaneous pop (count then stays unchanged)
//   pop         : read request; ignored when empty
//   head        : oldest entry, 0x00 while empty
//   full/empty  : decoded from the registered count
//   count       : number of stored entries
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/epp_host_bridge.sv
// -----------------------------------------------------------------------------
// epp_host_bridge
// Synchronous EPP host port driving NREG operand registers and a command FIFO
// for the graphics core.
//   clk, reset : system clock, asynchronous active-high reset
//   epp        : EPP strobes / EppWR / EppWait and the command port (slave side)
//   EppDB      : EPP data bus, driven only while serving a read
//   regs       : operand registers, reg i at bits [8i+7:8i]
// Address map: 0..NREG-1 operand regs, NREG command FIFO, NREG+1 status.
// An address write loads {ainc, addr} from EppDB; with ainc set, every data
// access to an operand register advances addr (wrapping after NREG-1).
// -----------------------------------------------------------------------------
module epp_host_bridge
    import epp_bridge_pkg::*;
#(
    parameter int NREG      = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    epp_host_bridge_if.slave     epp,
    inout  wire  [7:0]           EppDB,
    output logic [8*NREG-1:0]    regs
);
    localparam int         CNT_W  = $clog2(CMD_DEPTH) + 1;
    localparam logic [6:0] CMD_A  = CMD_ADDR(NREG);
    localparam logic [6:0] STAT_A = STAT_ADDR(NREG);
    localparam logic [6:0] NREG_A = 7'(NREG);
    localparam logic [6:0] LAST_A = 7'(NREG - 1);

    // Strobe / direction synchronisers; strobes reset to their idle (high) level
    // so a strobe still held low after reset is seen as a fresh access.
    logic astb_s1_q, astb_s2_q;
    logic dstb_s1_q, dstb_s2_q;
    logic wr_s1_q,   wr_s2_q;

    epp_state_t          state_q, state_d;
    logic [6:0]          addr_q, addr_d;
    logic                ainc_q, ainc_d;
    logic [8*NREG-1:0]   regs_q, regs_d;
    logic                rd_cyc_q, rd_cyc_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic [7:0]          wdata_q, wdata_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]          fifo_wdata, fifo_head;
    logic [CNT_W-1:0]    fifo_count;

    logic [7:0]          data_rd_val;
    logic [7:0]          rd_now;
    logic                rd_req;
    logic                db_oe;
    logic [7:0]          db_out;

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_pop      = !fifo_empty && epp.cmd_ready;
    assign epp.cmd_valid = !fifo_empty;
    assign epp.cmd_code  = fifo_head;
    assign regs          = regs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            astb_s1_q <= 1'b1;
            astb_s2_q <= 1'b1;
            dstb_s1_q <= 1'b1;
            dstb_s2_q <= 1'b1;
            wr_s1_q   <= 1'b0;
            wr_s2_q   <= 1'b0;
        end else begin
            astb_s1_q <= epp.EppAstb;
            astb_s2_q <= astb_s1_q;
            dstb_s1_q <= epp.EppDstb;
            dstb_s2_q <= dstb_s1_q;
            wr_s1_q   <= epp.EppWR;
            wr_s2_q   <= wr_s1_q;
        end
    end

    // Data-read mux for the current address; unmapped addresses read as 0x00.
    always_comb begin
        data_rd_val = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (addr_q == 7'(i)) begin
                data_rd_val = regs_q[8*i +: 8];
            end
        end
        if (addr_q == CMD_A) begin
            data_rd_val = fifo_head;
        end
        if (addr_q == STAT_A) begin
            data_rd_val = stat_byte(epp.busy, fifo_full, fifo_empty, int'(fifo_count));
        end
    end

    // Reads start driving the bus in the decision cycle, one cycle before
    // EppWait rises, and then hold the captured value until RELEASE exits.
    assign rd_req = (state_q == IDLE) && wr_s2_q && (!astb_s2_q || !dstb_s2_q);
    assign rd_now = !astb_s2_q ? {ainc_q, addr_q} : data_rd_val;
    assign db_oe  = rd_cyc_q || rd_req;
    assign db_out = (state_q == IDLE) ? rd_now : rd_data_q;
    assign EppDB  = db_oe ? db_out : 8'hzz;

    // Accesses complete on the edge that leaves IDLE, so the register update
    // and the rise of EppWait coincide.
    assign epp.EppWait = (state_q == AWR) || (state_q == ARD) || (state_q == DWR) ||
                         (state_q == DRD) || (state_q == RELEASE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ainc_d     = ainc_q;
        regs_d     = regs_q;
        rd_cyc_d   = rd_cyc_q;
        rd_data_d  = rd_data_q;
        wdata_d    = wdata_q;
        fifo_push  = 1'b0;
        fifo_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                rd_cyc_d = 1'b0;
                if (!astb_s2_q) begin
                    // Address strobe takes priority when both are low.
                    if (wr_s2_q) begin
                        rd_data_d = rd_now;
                        rd_cyc_d  = 1'b1;
                        state_d   = ARD;
                    end else begin
                        addr_d  = EppDB[6:0];
                        ainc_d  = EppDB[7];
                        state_d = AWR;
                    end
                end else if (!dstb_s2_q) begin
                    if (ainc_q && (addr_q < NREG_A)) begin
                        addr_d = (addr_q == LAST_A) ? 7'd0 : addr_q + 7'd1;
                    end
                    if (wr_s2_q) begin
                        rd_data_d = rd_now;
                        rd_cyc_d  = 1'b1;
                        state_d   = DRD;
                    end else begin
                        wdata_d = EppDB;
                        state_d = DWR;
                        if (addr_q == CMD_A) begin
                            if (fifo_full && !fifo_pop) begin
                                state_d = STALL;
                            end else begin
                                fifo_push  = 1'b1;
                                fifo_wdata = EppDB;
                            end
                        end else begin
                            for (int i = 0; i < NREG; i++) begin
                                if (addr_q == 7'(i)) begin
                                    regs_d[8*i +: 8] = EppDB;
                                end
                            end
                        end
                    end
                end
            end
            AWR, ARD, DWR, DRD: begin
                state_d = RELEASE;
            end
            STALL: begin
                // A pop in this cycle frees the slot the push needs.
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    state_d   = DWR;
                end
            end
            RELEASE: begin
                if (astb_s2_q && dstb_s2_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 7'd0;
            ainc_q   <= 1'b0;
            regs_q   <= '0;
            rd_cyc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ainc_q   <= ainc_d;
            regs_q   <= regs_d;
            rd_cyc_q <= rd_cyc_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        wdata_q   <= wdata_d;
    end
endmodule
